// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesters and rr_onehot_arbiter.
//   req         : per-requester request vector (requesters -> arbiter)
//   done        : end-of-transaction strobe from the current owner
//   grant       : registered one-hot grant vector, zero when idle
//   grant_idx   : binary index of the granted requester
//   grant_valid : high while a grant is held
//   timeout     : one-cycle pulse when the hold limit revokes a grant
// master = requester side, slave = arbiter side.
interface rr_onehot_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic                 done;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic                 grant_valid;
  logic                 timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter sharing one downstream resource among NUM_REQ
// requesters. The grant is registered, one-hot, and paired with its binary
// index. A grant is held until the owner pulses done, drops its request, or
// MAX_HOLD cycles elapse (MAX_HOLD=0 disables the limit). At least one idle
// cycle separates consecutive grants.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_onehot_arbiter_if.slave (req, done in; grant, grant_idx,
//         grant_valid, timeout out)
module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_onehot_arbiter_if.slave   bus
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);
  localparam int CNT_W     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  logic                 found_hi, found_any;
  logic [IDX_WIDTH-1:0] win_hi, win_any, win;

  // Rotating priority without modular arithmetic: the lowest requester at or
  // above ptr wins; if none, the lowest requester overall (the wrap-around).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = '0;
    win_any   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (bus.req[j] && !found_any) begin
        found_any = 1'b1;
        win_any   = IDX_WIDTH'(j);
      end
      if (bus.req[j] && !found_hi && (IDX_WIDTH'(j) >= ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = IDX_WIDTH'(j);
      end
    end
    win = found_hi ? win_hi : win_any;
  end

  logic owner_drop, hold_hit, release_now;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    owner_drop  = !bus.req[idx_q];
    hold_hit    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    release_now = bus.done || owner_drop || hold_hit;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        if (found_any) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << win;
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != HOLD_MAX) cnt_d = cnt_q + 1'b1;
        if (release_now) begin
          state_d   = IDLE;
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = (idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          // Timeout is reported only when the hold limit alone forced release.
          timeout_d = hold_hit && !bus.done && !owner_drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: a cycle-level reference model
// (owner / pointer / held-cycle count as plain integers) compared on every
// falling edge, plus directed scenarios with literal expectations.
module tb_rr_onehot_arbiter;
  localparam int N  = 4;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_onehot_arbiter_if #(.NUM_REQ(N)) bus ();

  rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: m_owner=-1 when idle; m_held counts cycles already held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_last  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && bus.req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_last  = m_owner;
            m_held  = 1;
          end
        end
      end else begin
        bit by_limit, by_done, by_drop;
        by_limit = (MH != 0) && (m_held == MH);
        by_done  = bus.done;
        by_drop  = !bus.req[m_owner];
        if (by_limit || by_done || by_drop) begin
          m_to    = by_limit && !by_done && !by_drop;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] exp_grant;
      exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      check("model_grant", int'(bus.grant), int'(exp_grant));
      check("model_valid", int'(bus.grant_valid), (m_owner >= 0) ? 1 : 0);
      check("model_idx", int'(bus.grant_idx), m_last);
      check("model_timeout", int'(bus.timeout), int'(m_to));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int g, input int v, input int idx, input int to);
    check({name, "_grant"}, int'(bus.grant), g);
    check({name, "_valid"}, int'(bus.grant_valid), v);
    if (v != 0) check({name, "_idx"}, int'(bus.grant_idx), idx);
    check({name, "_timeout"}, int'(bus.timeout), to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic [N-1:0] seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    expect_out("reset", 0, 0, 0, 0);
    check("reset_idx", int'(bus.grant_idx), 0);
    rst = 1'b0;

    // 1: single requester, done releases
    bus.req = 4'b0001;
    tick();
    expect_out("t1_grant", 4'b0001, 1, 0, 0);
    bus.done = 1'b1;
    tick();
    expect_out("t1_release", 0, 0, 0, 0);
    bus.done = 1'b0;

    // 2: all requesting, rotation starts at ptr=1
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      expect_out("t2_grant", int'(seq[g]), 1, $clog2(int'(seq[g])), 0);
      tick();
      bus.done = 1'b1;
      tick();
      expect_out("t2_gap", 0, 0, 0, 0);
      bus.done = 1'b0;
    end
    bus.req = 4'b1000;
    tick();
    expect_out("t3_owner3", 4'b1000, 1, 3, 0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // 3: wrap from owner 3 to requester 0
    bus.req = 4'b1001;
    tick();
    expect_out("t3_wrap", 4'b0001, 1, 0, 0);
    bus.req = 4'b0000;
    tick();
    expect_out("t3_drop", 0, 0, 0, 0);

    // 4: hold limit, then done on the last held cycle
    bus.req = 4'b0100;
    tick();
    expect_out("t4_first", 4'b0100, 1, 2, 0);
    for (int i = 1; i < MH; i++) tick();
    expect_out("t4_last_held", 4'b0100, 1, 2, 0);
    tick();
    expect_out("t4_timeout", 0, 0, 2, 1);
    tick();
    expect_out("t4_regrant", 4'b0100, 1, 2, 0);
    for (int i = 1; i < MH; i++) tick();
    bus.done = 1'b1;
    tick();
    expect_out("t4_done_wins", 0, 0, 2, 0);
    bus.done = 1'b0;
    bus.req  = '0;
    tick();

    // 5: owner drops its request while others keep requesting
    bus.req = 4'b0010;
    tick();
    expect_out("t5_owner1", 4'b0010, 1, 1, 0);
    bus.req = 4'b1101;
    tick();
    expect_out("t5_drop", 0, 0, 1, 0);
    tick();
    expect_out("t5_next", 4'b0100, 1, 2, 0);
    bus.req = '0;
    tick();

    // 6: asynchronous reset mid-grant
    bus.req = 4'b1000;
    tick();
    expect_out("t6_owner3", 4'b1000, 1, 3, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("t6_async", 0, 0, 0, 0);
    check("t6_async_idx", int'(bus.grant_idx), 0);
    bus.req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    expect_out("t6_after", 4'b0010, 1, 1, 0);

    // Mixed traffic checked by the model only
    for (int c = 0; c < 400; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0) bus.req = N'($urandom);
      bus.done = ($urandom_range(0, 5) == 0);
    end
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
